bus_reg_bank: RTL and testbench
===============================

Name: bus_reg_bank

Overview:
Parametrised bus-mapped register bank, successor to the fixed 8-bit x16 bank. Width, register count and read latency are configurable. Each register has a per-register access mode: RW, RO, W1C sticky status, or self-clearing PULSE. Adds out-of-range error reporting and per-register write strobes. Sits on the FPGA bus between the bus master (UART/SPI command decoder) and user logic.

Parameters:
DATA_WIDTH, 8, bits per register and bus data width (1..32)
ADDR_WIDTH, 4, bus address width; addresses >= NUM_REGS are out of range
NUM_REGS, 16, number of registers (1..2**ADDR_WIDTH)
RD_LATENCY, 1, cycles from read acceptance to o_Bus_Rd_DV (1..4)
RO_MASK, 0, NUM_REGS bits; bit i=1 -> register i is read-only
W1C_MASK, 0, NUM_REGS bits; bit i=1 -> register i is W1C sticky status
PULSE_MASK, 0, NUM_REGS bits; bit i=1 -> register i is self-clearing pulse
INIT_FLAT, 0, NUM_REGS*DATA_WIDTH; reset value of RW registers, reg i at bits [i*DW +: DW]

Ports:
i_Bus_Clk  in  1  bus clock, all logic on rising edge
i_Bus_Rst  in  1  synchronous, active-high reset
i_Bus_CS  in  1  command valid this cycle
i_Bus_Wr_Rd_n  in  1  1=write, 0=read
i_Bus_Addr  in  ADDR_WIDTH  register index
i_Bus_Wr_Data  in  DATA_WIDTH  write data
o_Bus_Rd_Data  out  DATA_WIDTH  read data, valid with o_Bus_Rd_DV
o_Bus_Rd_DV  out  1  one-cycle read-data-valid pulse
o_Bus_Rd_Err  out  1  qualifies o_Bus_Rd_DV: address was out of range
i_Reg_Flat  in  NUM_REGS*DATA_WIDTH  RO: read value; W1C: per-bit set events
o_Reg_Flat  out  NUM_REGS*DATA_WIDTH  current register contents to user logic
o_Reg_Wr_Strb  out  NUM_REGS  one-cycle pulse per accepted in-range write

Behaviour:
- Reset (i_Bus_Rst=1 at a clock edge): RW regs <= INIT_FLAT slice; W1C, PULSE and RO slices of o_Reg_Flat <= 0. o_Bus_Rd_Data=0, o_Bus_Rd_DV=0, o_Bus_Rd_Err=0, o_Reg_Wr_Strb=0. In-flight reads in the latency pipe are discarded; no DV after reset.
- Mode precedence when masks overlap: RO > W1C > PULSE > RW.
- Command is accepted on every edge with i_Bus_CS=1. No backpressure. Back-to-back commands are allowed every cycle.
- Write, in range, to register i, takes effect on the next edge:
  - RW: o_Reg <= data.
  - RO: ignored.
  - W1C: o_Reg <= (o_Reg & ~data) | set_i.
  - PULSE: o_Reg <= data for exactly one cycle, then 0.
- o_Reg_Wr_Strb[i]=1 for one cycle, aligned with the o_Reg update. This applies to RO targets too (strobe only, no data change).
- Write, out of range: no state change, no strobe, no error output.
- W1C set: every cycle, o_Reg |= set bits from i_Reg_Flat slice. When set and clear hit the same bit in the same cycle, set wins (bit stays 1).
- PULSE with no write: o_Reg = 0.
- Read, accepted at edge N: the value is sampled at that edge.
  - RW/W1C/PULSE return current o_Reg.
  - RO returns the i_Reg_Flat slice.
  - Out of range returns 0 with Err=1.
- Read pipeline: o_Bus_Rd_Data/Err/DV appear RD_LATENCY cycles later. Implemented as a RD_LATENCY-deep shift register of {valid, err, data}; one result per accepted read, in order. o_Bus_Rd_Data holds its last value when DV=0; Err=0 when DV=0.
- Read and write in consecutive cycles to the same register: the read at edge N sees the value before any write accepted at edge N. A write at N-1 is visible.
- Width rule: DATA_WIDTH applies throughout; no truncation or extension on the bus path.

Decomposition:
- Shared package bus_pkg holds:
  - access-mode encoding (MODE_RW, MODE_RO, MODE_W1C, MODE_PULSE) and a function mode_of(i) resolving precedence from the masks;
  - the reset value constant for the read-data output.
- One sub-module: bus_rd_pipe (parametrised RD_LATENCY x (DATA_WIDTH+2) shift register with sync reset), reusable by other bus slaves.
- Register storage uses a generate loop per register.

Test Plan:
1. Defaults DW=8, NUM_REGS=16, RD_LATENCY=1, INIT reg3=0xA5, reset -> o_Reg[3]=0xA5, others 0. Read addr 3 -> DV 1 cycle later, data=0xA5, Err=0.
2. DW=16, NUM_REGS=6, RO_MASK=6'b000010, i_Reg slice1=0x1234. Write 0xFFFF to addr 1 -> o_Reg[1] unchanged, strobe[1] pulses once. Read addr 1 -> 0x1234.
3. W1C_MASK bit 2: pulse set=0x0005 one cycle -> o_Reg[2]=0x0005. Write 0x0001 -> 0x0004. Write 0x0004 in the same cycle as set=0x0004 -> stays 0x0004.
4. PULSE_MASK bit 4: write 0x00F0 -> o_Reg[4]=0x00F0 for exactly one cycle, then 0. Read addr 4 afterwards -> 0.
5. RD_LATENCY=3: reads to addr 0, 7 (out of range, NUM_REGS=6), 1 on consecutive cycles -> three consecutive DV pulses starting 3 cycles later, in order. The middle one has data=0, Err=1.
6. Assert i_Bus_Rst one cycle after issuing two reads (RD_LATENCY=3) -> no DV ever emitted for them. All outputs return to reset values on the next edge.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared definitions for bus-mapped slaves: register access modes,
// mode precedence resolution and the read-data reset value.
package bus_pkg;

   // Access mode of one register in the bank.
   typedef enum logic [1:0] {
      MODE_RW    = 2'd0,
      MODE_RO    = 2'd1,
      MODE_W1C   = 2'd2,
      MODE_PULSE = 2'd3
   } bus_mode_e;

   // Value driven on the read-data output after reset (sliced to the bus width).
   localparam logic [31:0] RD_DATA_RST = 32'h0000_0000;

   // Resolve one register's mode from its mask bits; RO > W1C > PULSE > RW.
   function automatic bus_mode_e mode_of(input logic ro_bit,
                                         input logic w1c_bit,
                                         input logic pulse_bit);
      bus_mode_e mode;
      if (ro_bit) begin
         mode = MODE_RO;
      end else if (w1c_bit) begin
         mode = MODE_W1C;
      end else if (pulse_bit) begin
         mode = MODE_PULSE;
      end else begin
         mode = MODE_RW;
      end
      return mode;
   endfunction

endpackage

// File: rtl/bus_rd_pipe.sv
// Fixed-latency read-return pipe: RD_LATENCY stages of {valid, err, data}.
// Data only advances with a valid entry, so the last stage holds the most
// recent returned value while valid is low. Err is forced low with valid.
module bus_rd_pipe
   import bus_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int RD_LATENCY = 1
) (
   input  logic                  i_Bus_Clk,
   input  logic                  i_Bus_Rst,
   input  logic                  i_Vld,
   input  logic                  i_Err,
   input  logic [DATA_WIDTH-1:0] i_Data,
   output logic                  o_Vld,
   output logic                  o_Err,
   output logic [DATA_WIDTH-1:0] o_Data
);

   logic                  vld_r  [RD_LATENCY];
   logic                  err_r  [RD_LATENCY];
   logic [DATA_WIDTH-1:0] data_r [RD_LATENCY];

   // Shift read results toward the output; reset discards anything in flight.
   always_ff @(posedge i_Bus_Clk) begin
      if (i_Bus_Rst) begin
         for (int k = 0; k < RD_LATENCY; k++) begin
            vld_r[k]  <= 1'b0;
            err_r[k]  <= 1'b0;
            data_r[k] <= RD_DATA_RST[DATA_WIDTH-1:0];
         end
      end else begin
         vld_r[0] <= i_Vld;
         err_r[0] <= i_Vld & i_Err;
         if (i_Vld) begin
            data_r[0] <= i_Data;
         end
         for (int k = 1; k < RD_LATENCY; k++) begin
            vld_r[k] <= vld_r[k-1];
            err_r[k] <= err_r[k-1];
            if (vld_r[k-1]) begin
               data_r[k] <= data_r[k-1];
            end
         end
      end
   end

   assign o_Vld  = vld_r[RD_LATENCY-1];
   assign o_Err  = err_r[RD_LATENCY-1];
   assign o_Data = data_r[RD_LATENCY-1];

endmodule

// File: rtl/bus_reg_bank.sv
// Parametrised bus-mapped register bank with per-register RW / RO / W1C /
// PULSE access modes, per-register write strobes and out-of-range read error.
module bus_reg_bank
   import bus_pkg::*;
#(
   parameter int                             DATA_WIDTH = 8,
   parameter int                             ADDR_WIDTH = 4,
   parameter int                             NUM_REGS   = 16,
   parameter int                             RD_LATENCY = 1,
   parameter logic [NUM_REGS-1:0]            RO_MASK    = '0,
   parameter logic [NUM_REGS-1:0]            W1C_MASK   = '0,
   parameter logic [NUM_REGS-1:0]            PULSE_MASK = '0,
   parameter logic [NUM_REGS*DATA_WIDTH-1:0] INIT_FLAT  = '0
) (
   input  logic                           i_Bus_Clk,
   input  logic                           i_Bus_Rst,
   input  logic                           i_Bus_CS,
   input  logic                           i_Bus_Wr_Rd_n,
   input  logic [ADDR_WIDTH-1:0]          i_Bus_Addr,
   input  logic [DATA_WIDTH-1:0]          i_Bus_Wr_Data,
   output logic [DATA_WIDTH-1:0]          o_Bus_Rd_Data,
   output logic                           o_Bus_Rd_DV,
   output logic                           o_Bus_Rd_Err,
   input  logic [NUM_REGS*DATA_WIDTH-1:0] i_Reg_Flat,
   output logic [NUM_REGS*DATA_WIDTH-1:0] o_Reg_Flat,
   output logic [NUM_REGS-1:0]            o_Reg_Wr_Strb
);

   localparam logic [ADDR_WIDTH:0] NUM_REGS_W = (ADDR_WIDTH+1)'(NUM_REGS);

   logic                           rd_acc_s;
   logic                           addr_in_range_s;
   logic [DATA_WIDTH-1:0]          rd_data_s;
   logic                           rd_err_s;
   logic [DATA_WIDTH-1:0]          rd_view_s [NUM_REGS];
   logic [NUM_REGS*DATA_WIDTH-1:0] reg_flat_s;
   logic [NUM_REGS-1:0]            wr_strb_s;

   assign rd_acc_s        = i_Bus_CS & ~i_Bus_Wr_Rd_n;
   assign addr_in_range_s = ({1'b0, i_Bus_Addr} < NUM_REGS_W);

   for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
      localparam bus_mode_e MODE = mode_of(RO_MASK[i], W1C_MASK[i], PULSE_MASK[i]);
      localparam logic [DATA_WIDTH-1:0] RST_VAL =
         (MODE == MODE_RW) ? INIT_FLAT[i*DATA_WIDTH +: DATA_WIDTH] : {DATA_WIDTH{1'b0}};

      logic                  wr_hit_s;
      logic [DATA_WIDTH-1:0] ext_s;
      logic [DATA_WIDTH-1:0] reg_r;
      logic                  strb_r;

      assign wr_hit_s = i_Bus_CS & i_Bus_Wr_Rd_n & (i_Bus_Addr == ADDR_WIDTH'(i));
      assign ext_s    = i_Reg_Flat[i*DATA_WIDTH +: DATA_WIDTH];

      // Register update by access mode; strobe fires on any in-range write, RO included.
      always_ff @(posedge i_Bus_Clk) begin
         if (i_Bus_Rst) begin
            reg_r  <= RST_VAL;
            strb_r <= 1'b0;
         end else begin
            strb_r <= wr_hit_s;
            case (MODE)
               MODE_RW: begin
                  if (wr_hit_s) begin
                     reg_r <= i_Bus_Wr_Data;
                  end
               end
               MODE_RO:    reg_r <= {DATA_WIDTH{1'b0}};
               // Set is OR-ed after the clear so a simultaneous set wins.
               MODE_W1C:   reg_r <= (reg_r & ~(wr_hit_s ? i_Bus_Wr_Data : {DATA_WIDTH{1'b0}})) | ext_s;
               MODE_PULSE: reg_r <= wr_hit_s ? i_Bus_Wr_Data : {DATA_WIDTH{1'b0}};
               default:    reg_r <= RST_VAL;
            endcase
         end
      end

      assign reg_flat_s[i*DATA_WIDTH +: DATA_WIDTH] = reg_r;
      assign wr_strb_s[i]                           = strb_r;
      // RO registers read back the user-logic value, all others their own contents.
      assign rd_view_s[i] = (MODE == MODE_RO) ? ext_s : reg_r;
   end

   // Select read data by address; out-of-range addresses return zero with error.
   always_comb begin
      rd_data_s = {DATA_WIDTH{1'b0}};
      rd_err_s  = ~addr_in_range_s;
      for (int k = 0; k < NUM_REGS; k++) begin
         rd_data_s = rd_data_s |
                     ((i_Bus_Addr == ADDR_WIDTH'(k)) ? rd_view_s[k] : {DATA_WIDTH{1'b0}});
      end
   end

   bus_rd_pipe #(
      .DATA_WIDTH (DATA_WIDTH),
      .RD_LATENCY (RD_LATENCY)
   ) u_rd_pipe (
      .i_Bus_Clk (i_Bus_Clk),
      .i_Bus_Rst (i_Bus_Rst),
      .i_Vld     (rd_acc_s),
      .i_Err     (rd_err_s),
      .i_Data    (rd_data_s),
      .o_Vld     (o_Bus_Rd_DV),
      .o_Err     (o_Bus_Rd_Err),
      .o_Data    (o_Bus_Rd_Data)
   );

   assign o_Reg_Flat    = reg_flat_s;
   assign o_Reg_Wr_Strb = wr_strb_s;

endmodule

// File: tb/tb_bus_reg_bank.sv
// Directed self-checking bench for bus_reg_bank: one default-configured
// instance (8-bit x16, latency 1) and one 16-bit x6 instance with RO, W1C
// and PULSE registers and read latency 3.
module tb_bus_reg_bank;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Instance A signals
   logic         rst_a, cs_a, wr_a;
   logic [3:0]   addr_a;
   logic [7:0]   wdata_a, rdata_a;
   logic         dv_a, err_a;
   logic [127:0] ireg_a, oreg_a;
   logic [15:0]  strb_a;

   // Instance B signals
   logic         rst_b, cs_b, wr_b;
   logic [3:0]   addr_b;
   logic [15:0]  wdata_b, rdata_b;
   logic         dv_b, err_b;
   logic [95:0]  ireg_b, oreg_b;
   logic [5:0]   strb_b;

   bus_reg_bank #(
      .INIT_FLAT (128'h0000_0000_0000_0000_0000_0000_A500_0000)
   ) dut_a (
      .i_Bus_Clk     (clk),
      .i_Bus_Rst     (rst_a),
      .i_Bus_CS      (cs_a),
      .i_Bus_Wr_Rd_n (wr_a),
      .i_Bus_Addr    (addr_a),
      .i_Bus_Wr_Data (wdata_a),
      .o_Bus_Rd_Data (rdata_a),
      .o_Bus_Rd_DV   (dv_a),
      .o_Bus_Rd_Err  (err_a),
      .i_Reg_Flat    (ireg_a),
      .o_Reg_Flat    (oreg_a),
      .o_Reg_Wr_Strb (strb_a)
   );

   bus_reg_bank #(
      .DATA_WIDTH (16),
      .ADDR_WIDTH (4),
      .NUM_REGS   (6),
      .RD_LATENCY (3),
      .RO_MASK    (6'b000010),
      .W1C_MASK   (6'b000100),
      .PULSE_MASK (6'b010000),
      .INIT_FLAT  (96'h0)
   ) dut_b (
      .i_Bus_Clk     (clk),
      .i_Bus_Rst     (rst_b),
      .i_Bus_CS      (cs_b),
      .i_Bus_Wr_Rd_n (wr_b),
      .i_Bus_Addr    (addr_b),
      .i_Bus_Wr_Data (wdata_b),
      .o_Bus_Rd_Data (rdata_b),
      .o_Bus_Rd_DV   (dv_b),
      .o_Bus_Rd_Err  (err_b),
      .i_Reg_Flat    (ireg_b),
      .o_Reg_Flat    (oreg_b),
      .o_Reg_Wr_Strb (strb_b)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cmd_a(input logic wr, input logic [3:0] addr, input logic [7:0] data);
      cs_a = 1'b1; wr_a = wr; addr_a = addr; wdata_a = data;
   endtask

   task automatic idle_a();
      cs_a = 1'b0; wr_a = 1'b0; addr_a = 4'd0; wdata_a = 8'h00;
   endtask

   task automatic cmd_b(input logic wr, input logic [3:0] addr, input logic [15:0] data);
      cs_b = 1'b1; wr_b = wr; addr_b = addr; wdata_b = data;
   endtask

   task automatic idle_b();
      cs_b = 1'b0; wr_b = 1'b0; addr_b = 4'd0; wdata_b = 16'h0000;
   endtask

   task automatic test_reset();
      rst_a = 1'b1; rst_b = 1'b1;
      tick();
      n_checks++;
      if (oreg_a !== 128'h0000_0000_0000_0000_0000_0000_A500_0000) begin
         n_fail++; $display("FAIL reset_oreg_a got %h want reg3=A5 others 0", oreg_a);
      end
      n_checks++;
      if ({dv_a, err_a, rdata_a, strb_a} !== {1'b0, 1'b0, 8'h00, 16'h0000}) begin
         n_fail++; $display("FAIL reset_outs_a got dv=%b err=%b data=%h strb=%h want all 0", dv_a, err_a, rdata_a, strb_a);
      end
      n_checks++;
      if ({dv_b, err_b, rdata_b, strb_b, oreg_b} !== {1'b0, 1'b0, 16'h0000, 6'h00, 96'h0}) begin
         n_fail++; $display("FAIL reset_outs_b got dv=%b err=%b data=%h strb=%h oreg=%h want all 0", dv_b, err_b, rdata_b, strb_b, oreg_b);
      end
      rst_a = 1'b0; rst_b = 1'b0;
   endtask

   task automatic test_rw_latency1();
      cmd_a(1'b0, 4'd3, 8'h00);
      tick();
      idle_a();
      n_checks++;
      if ({dv_a, err_a, rdata_a} !== {1'b1, 1'b0, 8'hA5}) begin
         n_fail++; $display("FAIL read_init_reg3 got dv=%b err=%b data=%h want dv=1 err=0 data=a5", dv_a, err_a, rdata_a);
      end
      cmd_a(1'b1, 4'd5, 8'h3C);
      tick();
      idle_a();
      n_checks++;
      if (oreg_a[47:40] !== 8'h3C || strb_a !== 16'h0020 || dv_a !== 1'b0) begin
         n_fail++; $display("FAIL rw_write_reg5 got reg=%h strb=%h dv=%b want reg=3c strb=0020 dv=0", oreg_a[47:40], strb_a, dv_a);
      end
      tick();
      n_checks++;
      if (strb_a !== 16'h0000 || oreg_a[47:40] !== 8'h3C) begin
         n_fail++; $display("FAIL rw_strobe_one_cycle got strb=%h reg=%h want strb=0000 reg=3c", strb_a, oreg_a[47:40]);
      end
   endtask

   task automatic test_back_to_back();
      cmd_a(1'b1, 4'd5, 8'h77);
      tick();
      cmd_a(1'b0, 4'd5, 8'h00);
      tick();
      idle_a();
      n_checks++;
      if ({dv_a, err_a, rdata_a} !== {1'b1, 1'b0, 8'h77}) begin
         n_fail++; $display("FAIL b2b_read_after_write got dv=%b err=%b data=%h want dv=1 err=0 data=77", dv_a, err_a, rdata_a);
      end
      tick();
      n_checks++;
      if ({dv_a, err_a, rdata_a} !== {1'b0, 1'b0, 8'h77}) begin
         n_fail++; $display("FAIL b2b_data_hold got dv=%b err=%b data=%h want dv=0 err=0 data=77", dv_a, err_a, rdata_a);
      end
   endtask

   task automatic test_ro();
      ireg_b[31:16] = 16'h1234;
      cmd_b(1'b1, 4'd1, 16'hFFFF);
      tick();
      idle_b();
      n_checks++;
      if (oreg_b[31:16] !== 16'h0000 || strb_b !== 6'b000010) begin
         n_fail++; $display("FAIL ro_write_ignored got reg=%h strb=%b want reg=0000 strb=000010", oreg_b[31:16], strb_b);
      end
      cmd_b(1'b0, 4'd1, 16'h0000);
      tick();
      idle_b();
      n_checks++;
      if (strb_b !== 6'b000000 || dv_b !== 1'b0) begin
         n_fail++; $display("FAIL ro_strobe_single got strb=%b dv=%b want strb=000000 dv=0", strb_b, dv_b);
      end
      tick();
      tick();
      n_checks++;
      if ({dv_b, err_b, rdata_b} !== {1'b1, 1'b0, 16'h1234}) begin
         n_fail++; $display("FAIL ro_read got dv=%b err=%b data=%h want dv=1 err=0 data=1234", dv_b, err_b, rdata_b);
      end
   endtask

   task automatic test_w1c();
      ireg_b[47:32] = 16'h0005;
      tick();
      ireg_b[47:32] = 16'h0000;
      n_checks++;
      if (oreg_b[47:32] !== 16'h0005) begin
         n_fail++; $display("FAIL w1c_set got %h want 0005", oreg_b[47:32]);
      end
      cmd_b(1'b1, 4'd2, 16'h0001);
      tick();
      idle_b();
      n_checks++;
      if (oreg_b[47:32] !== 16'h0004 || strb_b !== 6'b000100) begin
         n_fail++; $display("FAIL w1c_clear got reg=%h strb=%b want reg=0004 strb=000100", oreg_b[47:32], strb_b);
      end
      cmd_b(1'b1, 4'd2, 16'h0004);
      ireg_b[47:32] = 16'h0004;
      tick();
      idle_b();
      ireg_b[47:32] = 16'h0000;
      n_checks++;
      if (oreg_b[47:32] !== 16'h0004) begin
         n_fail++; $display("FAIL w1c_set_wins got %h want 0004", oreg_b[47:32]);
      end
      cmd_b(1'b1, 4'd2, 16'h0004);
      tick();
      idle_b();
      n_checks++;
      if (oreg_b[47:32] !== 16'h0000) begin
         n_fail++; $display("FAIL w1c_clear_last got %h want 0000", oreg_b[47:32]);
      end
   endtask

   task automatic test_pulse();
      cmd_b(1'b1, 4'd4, 16'h00F0);
      tick();
      idle_b();
      n_checks++;
      if (oreg_b[79:64] !== 16'h00F0 || strb_b !== 6'b010000) begin
         n_fail++; $display("FAIL pulse_high got reg=%h strb=%b want reg=00f0 strb=010000", oreg_b[79:64], strb_b);
      end
      tick();
      n_checks++;
      if (oreg_b[79:64] !== 16'h0000) begin
         n_fail++; $display("FAIL pulse_clear got %h want 0000", oreg_b[79:64]);
      end
      cmd_b(1'b0, 4'd4, 16'h0000);
      tick();
      idle_b();
      tick();
      tick();
      n_checks++;
      if ({dv_b, err_b, rdata_b} !== {1'b1, 1'b0, 16'h0000}) begin
         n_fail++; $display("FAIL pulse_read got dv=%b err=%b data=%h want dv=1 err=0 data=0000", dv_b, err_b, rdata_b);
      end
   endtask

   task automatic test_latency3_range();
      tick(); tick(); tick();
      cmd_b(1'b1, 4'd0, 16'hBEEF);
      tick();
      cmd_b(1'b0, 4'd0, 16'h0000);
      tick();
      n_checks++;
      if (dv_b !== 1'b0) begin
         n_fail++; $display("FAIL lat3_early_dv0 got dv=%b want 0", dv_b);
      end
      cmd_b(1'b0, 4'd7, 16'h0000);
      tick();
      n_checks++;
      if (dv_b !== 1'b0) begin
         n_fail++; $display("FAIL lat3_early_dv1 got dv=%b want 0", dv_b);
      end
      cmd_b(1'b0, 4'd1, 16'h0000);
      tick();
      idle_b();
      n_checks++;
      if ({dv_b, err_b, rdata_b} !== {1'b1, 1'b0, 16'hBEEF}) begin
         n_fail++; $display("FAIL lat3_first got dv=%b err=%b data=%h want dv=1 err=0 data=beef", dv_b, err_b, rdata_b);
      end
      tick();
      n_checks++;
      if ({dv_b, err_b, rdata_b} !== {1'b1, 1'b1, 16'h0000}) begin
         n_fail++; $display("FAIL lat3_out_of_range got dv=%b err=%b data=%h want dv=1 err=1 data=0000", dv_b, err_b, rdata_b);
      end
      tick();
      n_checks++;
      if ({dv_b, err_b, rdata_b} !== {1'b1, 1'b0, 16'h1234}) begin
         n_fail++; $display("FAIL lat3_third got dv=%b err=%b data=%h want dv=1 err=0 data=1234", dv_b, err_b, rdata_b);
      end
      tick();
      n_checks++;
      if ({dv_b, err_b, rdata_b} !== {1'b0, 1'b0, 16'h1234}) begin
         n_fail++; $display("FAIL lat3_idle_hold got dv=%b err=%b data=%h want dv=0 err=0 data=1234", dv_b, err_b, rdata_b);
      end
      cmd_b(1'b1, 4'd9, 16'hFFFF);
      tick();
      cmd_b(1'b1, 4'd6, 16'hFFFF);
      tick();
      idle_b();
      n_checks++;
      if (strb_b !== 6'b000000 || oreg_b !== 96'h0000_0000_0000_0000_0000_BEEF || err_b !== 1'b0) begin
         n_fail++; $display("FAIL oor_write got strb=%b oreg=%h err=%b want strb=000000 oreg=..beef err=0", strb_b, oreg_b, err_b);
      end
   endtask

   task automatic test_reset_flush();
      int dv_seen;
      dv_seen = 0;
      cmd_b(1'b0, 4'd0, 16'h0000);
      tick();
      cmd_b(1'b0, 4'd1, 16'h0000);
      tick();
      idle_b();
      rst_b = 1'b1;
      tick();
      n_checks++;
      if ({dv_b, err_b, rdata_b, strb_b, oreg_b} !== {1'b0, 1'b0, 16'h0000, 6'h00, 96'h0}) begin
         n_fail++; $display("FAIL flush_reset_outs got dv=%b err=%b data=%h strb=%b oreg=%h want all 0", dv_b, err_b, rdata_b, strb_b, oreg_b);
      end
      rst_b = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (dv_b === 1'b1) dv_seen++;
      end
      n_checks++;
      if (dv_seen !== 0) begin
         n_fail++; $display("FAIL flush_no_dv got %0d dv pulses want 0", dv_seen);
      end
   endtask

   initial begin
      rst_a = 1'b1; rst_b = 1'b1;
      idle_a(); idle_b();
      ireg_a = 128'h0;
      ireg_b = 96'h0;
      #2;
      test_reset();
      test_rw_latency1();
      test_back_to_back();
      test_ro();
      test_w1c();
      test_pulse();
      test_latency3_range();
      test_reset_flush();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
